// File: rtl/common_pkg.sv
// Shared definitions for the load/store path: operand width and the
// RISC-V funct3 access-size encoding.
package common;

  localparam int OPERAND_WIDTH = 32;

  typedef enum logic [2:0] {
    SIZE_B    = 3'b000,
    SIZE_H    = 3'b001,
    SIZE_W    = 3'b010,
    SIZE_D    = 3'b011,
    SIZE_BU   = 3'b100,
    SIZE_HU   = 3'b101,
    SIZE_WU   = 3'b110,
    SIZE_RSVD = 3'b111
  } mem_size_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for stores, lane selection plus sign/zero
// extension for loads, and the alignment/legality check for a request.
module lsu_align
  import common::*;
#(
  parameter int  XLEN = OPERAND_WIDTH,
  localparam int NB   = XLEN / 8,
  localparam int OB   = $clog2(NB)
) (
  input  mem_size_e         st_size,
  input  logic [OB-1:0]     st_offset,
  input  logic [XLEN-1:0]   st_wdata,
  output logic [NB-1:0]     st_be,
  output logic [XLEN-1:0]   st_data,
  output logic              st_illegal,
  input  mem_size_e         ld_size,
  input  logic [OB-1:0]     ld_offset,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [XLEN-1:0]   ld_data
);

  logic [NB-1:0]   be_base_s;
  logic [2:0]      off3_s;
  logic [XLEN-1:0] shifted_s;

  // Store path: replicate the datum over every lane of its width and build
  // the byte enables as the size mask moved to the addressed lane.
  always_comb begin
    be_base_s = {NB{1'b0}};
    st_data   = {XLEN{1'b0}};
    case (st_size)
      SIZE_B, SIZE_BU: begin
        be_base_s = NB'(1'b1);
        st_data   = {NB{st_wdata[7:0]}};
      end
      SIZE_H, SIZE_HU: begin
        be_base_s = NB'(2'b11);
        st_data   = {(NB / 2){st_wdata[15:0]}};
      end
      SIZE_W, SIZE_WU: begin
        be_base_s = NB'(4'hF);
        st_data   = {(XLEN / 32){st_wdata[31:0]}};
      end
      SIZE_D: begin
        be_base_s = {NB{1'b1}};
        st_data   = st_wdata;
      end
      default: begin
        be_base_s = {NB{1'b0}};
        st_data   = {XLEN{1'b0}};
      end
    endcase
    st_be = be_base_s << st_offset;
  end

  // Legality: natural alignment per size; doubleword and WU only exist on
  // a 64-bit datapath; the reserved encoding is always rejected.
  always_comb begin
    off3_s     = 3'(st_offset);
    st_illegal = 1'b0;
    case (st_size)
      SIZE_B, SIZE_BU: st_illegal = 1'b0;
      SIZE_H, SIZE_HU: st_illegal = off3_s[0];
      SIZE_W:          st_illegal = |off3_s[1:0];
      SIZE_WU:         st_illegal = (XLEN == 32) ? 1'b1 : |off3_s[1:0];
      SIZE_D:          st_illegal = (XLEN == 32) ? 1'b1 : |off3_s[2:0];
      default:         st_illegal = 1'b1;
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_s = ld_rdata >> {ld_offset, 3'b000};
    ld_data   = {XLEN{1'b0}};
    case (ld_size)
      SIZE_B:  ld_data = XLEN'($signed(shifted_s[7:0]));
      SIZE_BU: ld_data = XLEN'(shifted_s[7:0]);
      SIZE_H:  ld_data = XLEN'($signed(shifted_s[15:0]));
      SIZE_HU: ld_data = XLEN'(shifted_s[15:0]);
      SIZE_W:  ld_data = XLEN'($signed(shifted_s[31:0]));
      SIZE_WU: ld_data = XLEN'(shifted_s[31:0]);
      SIZE_D:  ld_data = shifted_s;
      default: ld_data = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one pipeline access at a time, drives a simple
// req/gnt + rvalid bus, and returns a single-cycle completion pulse with
// extended load data or an error code.
module lsu
  import common::*;
#(
  parameter int XLEN       = OPERAND_WIDTH,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [XLEN/8-1:0]     mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  busy
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("lsu: XLEN must be 32 or 64");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("lsu: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  state_e          state_r, state_n_s;
  logic [CW-1:0]   cnt_r;
  logic            cnt_last_s;
  logic            accept_s;
  logic            timeout_s;

  logic            write_r;
  mem_size_e       size_r;
  logic [OB-1:0]   offset_r;

  logic [NB-1:0]   st_be_s;
  logic [XLEN-1:0] st_data_s;
  logic            illegal_s;
  logic [XLEN-1:0] ld_data_s;

  logic                  req_ready_r;
  logic                  busy_r;
  logic                  mem_req_r;
  logic                  mem_we_r;
  logic [NB-1:0]         mem_be_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [XLEN-1:0]       mem_wdata_r;
  logic                  resp_valid_r;
  logic [XLEN-1:0]       resp_rdata_r;
  logic [1:0]            resp_err_r;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size    (mem_size_e'(req_size)),
    .st_offset  (req_addr[OB-1:0]),
    .st_wdata   (req_wdata),
    .st_be      (st_be_s),
    .st_data    (st_data_s),
    .st_illegal (illegal_s),
    .ld_size    (size_r),
    .ld_offset  (offset_r),
    .ld_rdata   (mem_rdata),
    .ld_data    (ld_data_s)
  );

  // The count for the current REQ/WAIT phase hits its limit this cycle.
  assign cnt_last_s = (cnt_r == CW'(TIMEOUT - 1));

  // Next-state decode; a grant or read data arriving together with the
  // last counted cycle takes priority over the timeout.
  always_comb begin
    state_n_s = state_r;
    accept_s  = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s  = 1'b1;
          state_n_s = illegal_s ? ST_RESP : ST_REQ;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_n_s = write_r ? ST_RESP : ST_WAIT;
        end else if (cnt_last_s) begin
          state_n_s = ST_RESP;
          timeout_s = 1'b1;
        end else begin
          state_n_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_n_s = ST_RESP;
        end else if (cnt_last_s) begin
          state_n_s = ST_RESP;
          timeout_s = 1'b1;
        end else begin
          state_n_s = ST_WAIT;
        end
      end
      ST_RESP: state_n_s = ST_IDLE;
      default: state_n_s = ST_IDLE;
    endcase
  end

  // State register and the status outputs that follow directly from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      mem_req_r    <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      req_ready_r  <= (state_n_s == ST_IDLE);
      busy_r       <= (state_n_s != ST_IDLE);
      mem_req_r    <= (state_n_s == ST_REQ);
      resp_valid_r <= (state_n_s == ST_RESP);
    end
  end

  // Timeout counter; restarts on acceptance and again on grant so the
  // grant wait and the data wait each get the full budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (accept_s || (state_r == ST_REQ && mem_gnt)) begin
      cnt_r <= {CW{1'b0}};
    end else if (state_r == ST_REQ || state_r == ST_WAIT) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Latch the request and the steered bus fields; they stay frozen for the
  // whole REQ phase and are cleared once the bus phase ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_r     <= 1'b0;
      size_r      <= SIZE_B;
      offset_r    <= {OB{1'b0}};
      mem_we_r    <= 1'b0;
      mem_be_r    <= {NB{1'b0}};
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {XLEN{1'b0}};
    end else if (accept_s) begin
      write_r     <= req_write;
      size_r      <= mem_size_e'(req_size);
      offset_r    <= req_addr[OB-1:0];
      mem_we_r    <= req_write & ~illegal_s;
      mem_be_r    <= illegal_s ? {NB{1'b0}} : st_be_s;
      mem_addr_r  <= illegal_s ? {ADDR_WIDTH{1'b0}}
                               : {req_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
      mem_wdata_r <= (illegal_s || !req_write) ? {XLEN{1'b0}} : st_data_s;
    end else if (state_r == ST_REQ && state_n_s != ST_REQ) begin
      mem_we_r    <= 1'b0;
      mem_be_r    <= {NB{1'b0}};
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {XLEN{1'b0}};
    end else begin
      mem_we_r    <= mem_we_r;
    end
  end

  // Response payload: error bits and load data are only non-zero on the
  // cycle the completion pulse is shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err_r   <= 2'b00;
      resp_rdata_r <= {XLEN{1'b0}};
    end else begin
      resp_err_r   <= {timeout_s, accept_s & illegal_s};
      resp_rdata_r <= (state_r == ST_WAIT && mem_rvalid) ? ld_data_s
                                                          : {XLEN{1'b0}};
    end
  end

  assign req_ready  = req_ready_r;
  assign busy       = busy_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_be     = mem_be_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a 32-bit instance for most scenarios and a
// 64-bit instance for the doubleword/WU paths.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, resp_rdata;
  logic        resp_valid, busy;
  logic [1:0]  resp_err;

  logic        q_valid, q_write, q_ready, m_req, m_we, m_gnt, m_rvalid;
  logic [2:0]  q_size;
  logic [31:0] q_addr, m_addr;
  logic [63:0] q_wdata, m_wdata, m_rdata, r_rdata;
  logic [7:0]  m_be;
  logic        r_valid, q_busy;
  logic [1:0]  r_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  lsu #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .req_valid(q_valid), .req_ready(q_ready),
    .req_write(q_write), .req_size(q_size), .req_addr(q_addr),
    .req_wdata(q_wdata), .mem_req(m_req), .mem_we(m_we),
    .mem_be(m_be), .mem_addr(m_addr), .mem_wdata(m_wdata),
    .mem_gnt(m_gnt), .mem_rvalid(m_rvalid), .mem_rdata(m_rdata),
    .resp_valid(r_valid), .resp_rdata(r_rdata), .resp_err(r_err),
    .busy(q_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns just after acceptance.
  task automatic issue(input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic issue64(input logic wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [63:0] wd);
    q_valid = 1'b1; q_write = wr; q_size = sz; q_addr = a; q_wdata = wd;
    tick();
    q_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({req_ready, busy, mem_req, mem_we, resp_valid} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 10000", {req_ready, busy, mem_req, mem_we, resp_valid});
    end
    n_tests++;
    if ({mem_be, mem_addr, mem_wdata, resp_rdata, resp_err} !== 102'd0) begin
      n_fail++;
      $display("FAIL reset_data be=%h addr=%h wd=%h rd=%h err=%b exp all zero",
               mem_be, mem_addr, mem_wdata, resp_rdata, resp_err);
    end
    n_tests++;
    if ({q_ready, q_busy, m_req, r_valid, m_be, r_rdata} !== {4'b1000, 72'd0}) begin
      n_fail++;
      $display("FAIL reset_64 got ready=%b busy=%b req=%b valid=%b be=%h rd=%h",
               q_ready, q_busy, m_req, r_valid, m_be, r_rdata);
    end
  endtask

  task automatic test_store_byte();
    mem_gnt = 1'b1;
    issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
    n_tests++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid} !==
        {1'b1, 1'b1, 4'b1000, 32'h0000_0100, 32'hA5A5_A5A5, 1'b0}) begin
      n_fail++;
      $display("FAIL sb_bus got req=%b we=%b be=%b addr=%h wd=%h rv=%b exp 1 1 1000 100 a5a5a5a5 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid);
    end
    tick();
    n_tests++;
    if ({resp_valid, resp_err, resp_rdata, mem_req} !== {1'b1, 2'b00, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL sb_resp got rv=%b err=%b rd=%h req=%b exp 1 00 0 0",
               resp_valid, resp_err, resp_rdata, mem_req);
    end
    tick();
    n_tests++;
    if ({resp_valid, req_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL sb_idle got %b exp 010", {resp_valid, req_ready, busy});
    end
    mem_gnt = 1'b0;
  endtask

  task automatic test_store_held();
    logic bad = 1'b0;
    mem_gnt = 1'b0;
    issue(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      if ({mem_req, mem_be, mem_addr, mem_wdata, resp_valid, req_ready} !==
          {1'b1, 4'hF, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 1'b0}) bad = 1'b1;
      tick();
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_hold got unstable bus be=%h addr=%h wd=%h exp f 104 deadbeef",
               mem_be, mem_addr, mem_wdata);
    end
    mem_gnt = 1'b1;
    tick();
    n_tests++;
    if ({resp_valid, resp_err, mem_req} !== 4'b1000) begin
      n_fail++;
      $display("FAIL sw_resp got %b exp 1000", {resp_valid, resp_err, mem_req});
    end
    tick();
    issue(1'b1, 3'b001, 32'h0000_0102, 32'hFFFF_1234);
    n_tests++;
    if ({mem_be, mem_wdata} !== {4'b1100, 32'h1234_1234}) begin
      n_fail++;
      $display("FAIL sh_bus got be=%b wd=%h exp 1100 12341234", mem_be, mem_wdata);
    end
    tick(); tick();
    mem_gnt = 1'b0;
  endtask

  task automatic test_loads();
    logic [31:0] a_t [5] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h108};
    logic [2:0]  s_t [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] d_t [5] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000,
                             32'h8001_0000, 32'h8000_0000};
    logic [31:0] e_t [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                             32'h0000_8001, 32'h8000_0000};
    logic [3:0]  b_t [5] = '{4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b1111};
    for (int i = 0; i < 5; i++) begin
      mem_gnt = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 32'h5555_5555;
      issue(1'b0, s_t[i], a_t[i], 32'h0);
      n_tests++;
      if ({mem_req, mem_we, mem_be} !== {1'b1, 1'b0, b_t[i]}) begin
        n_fail++;
        $display("FAIL load%0d_bus got req=%b we=%b be=%b exp 1 0 %b",
                 i, mem_req, mem_we, mem_be, b_t[i]);
      end
      tick();
      mem_gnt = 1'b0;
      mem_rdata = d_t[i];
      n_tests++;
      if ({resp_valid, mem_req, busy} !== 3'b001) begin
        n_fail++;
        $display("FAIL load%0d_wait got %b exp 001", i, {resp_valid, mem_req, busy});
      end
      tick();
      mem_rvalid = 1'b0;
      n_tests++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 2'b00, e_t[i]}) begin
        n_fail++;
        $display("FAIL load%0d_data got rv=%b err=%b rd=%h exp 1 00 %h",
                 i, resp_valid, resp_err, resp_rdata, e_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic       w_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] s_t [5] = '{3'b001, 3'b011, 3'b111, 3'b010, 3'b110};
    logic [31:0] a_t [5] = '{32'h101, 32'h100, 32'h100, 32'h102, 32'h100};
    mem_gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(w_t[i], s_t[i], a_t[i], 32'hFFFF_FFFF);
      n_tests++;
      if ({resp_valid, resp_err, mem_req, resp_rdata} !== {1'b1, 2'b01, 1'b0, 32'd0}) begin
        n_fail++;
        $display("FAIL illegal%0d got rv=%b err=%b req=%b rd=%h exp 1 01 0 0",
                 i, resp_valid, resp_err, mem_req, resp_rdata);
      end
      tick();
      n_tests++;
      if ({resp_valid, mem_req, req_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL illegal%0d_after got %b exp 001", i, {resp_valid, mem_req, req_ready});
      end
    end
    mem_gnt = 1'b0;
  endtask

  task automatic test_req_timeout();
    logic bad = 1'b0;
    mem_gnt = 1'b0;
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    for (int i = 0; i < 15; i++) begin
      if (mem_req !== 1'b1 || resp_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL req_to_hold got early drop exp mem_req for 15 cycles");
    end
    n_tests++;
    if ({resp_valid, resp_err, mem_req, resp_rdata} !== {1'b1, 2'b10, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL req_to_resp got rv=%b err=%b req=%b rd=%h exp 1 10 0 0",
               resp_valid, resp_err, mem_req, resp_rdata);
    end
    tick();
    // Grant on the last allowed REQ cycle must complete without error.
    issue(1'b1, 3'b010, 32'h0000_0100, 32'h1);
    for (int i = 0; i < 14; i++) tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    n_tests++;
    if ({resp_valid, resp_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL req_race got %b exp 100", {resp_valid, resp_err});
    end
    tick();
  endtask

  task automatic test_wait_timeout(input logic give);
    logic bad = 1'b0;
    mem_gnt = 1'b1;
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (resp_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      tick();
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_hold%0d got early response", give);
    end
    mem_rvalid = give;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    n_tests++;
    if (give && {resp_valid, resp_err, resp_rdata} !== {1'b1, 2'b00, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL wait_race got rv=%b err=%b rd=%h exp 1 00 12345678",
               resp_valid, resp_err, resp_rdata);
    end else if (!give && {resp_valid, resp_err, resp_rdata} !== {1'b1, 2'b10, 32'd0}) begin
      n_fail++;
      $display("FAIL wait_to got rv=%b err=%b rd=%h exp 1 10 0",
               resp_valid, resp_err, resp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    mem_gnt = 1'b1;
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    n_tests++;
    if ({mem_req, req_ready, resp_valid, busy} !== 4'b0100) begin
      n_fail++;
      $display("FAIL rst_wait got %b exp 0100", {mem_req, req_ready, resp_valid, busy});
    end
    tick();
    mem_rvalid = 1'b0;
    n_tests++;
    if ({resp_valid, req_ready, resp_rdata} !== {2'b01, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_late got rv=%b rdy=%b rd=%h exp 0 1 0", resp_valid, req_ready, resp_rdata);
    end
    issue(1'b1, 3'b010, 32'h0000_0100, 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({mem_req, mem_we, resp_valid, req_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_req got %b exp 0001", {mem_req, mem_we, resp_valid, req_ready});
    end
  endtask

  task automatic test_xlen64();
    logic [2:0]  s_t [2] = '{3'b110, 3'b010};
    logic [63:0] e_t [2] = '{64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001};
    m_gnt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue64(1'b0, s_t[i], 32'h0000_0004, 64'h0);
      n_tests++;
      if ({m_req, m_be, m_addr} !== {1'b1, 8'hF0, 32'h0}) begin
        n_fail++;
        $display("FAIL x64_ld%0d_bus got req=%b be=%h addr=%h exp 1 f0 0", i, m_req, m_be, m_addr);
      end
      tick();
      m_rvalid = 1'b1;
      m_rdata = 64'h8000_0001_DEAD_BEEF;
      tick();
      m_rvalid = 1'b0;
      n_tests++;
      if ({r_valid, r_err, r_rdata} !== {1'b1, 2'b00, e_t[i]}) begin
        n_fail++;
        $display("FAIL x64_ld%0d got rv=%b err=%b rd=%h exp 1 00 %h", i, r_valid, r_err, r_rdata, e_t[i]);
      end
      tick();
    end
    issue64(1'b1, 3'b000, 32'h0000_0105, 64'h5A);
    n_tests++;
    if ({m_be, m_addr, m_wdata} !== {8'h20, 32'h0000_0100, 64'h5A5A_5A5A_5A5A_5A5A}) begin
      n_fail++;
      $display("FAIL x64_sb got be=%h addr=%h wd=%h exp 20 100 5a5a5a5a5a5a5a5a", m_be, m_addr, m_wdata);
    end
    tick(); tick();
    issue64(1'b1, 3'b011, 32'h0000_0108, 64'h0123_4567_89AB_CDEF);
    n_tests++;
    if ({m_req, m_be, m_wdata} !== {1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF}) begin
      n_fail++;
      $display("FAIL x64_sd got req=%b be=%h wd=%h exp 1 ff 0123456789abcdef", m_req, m_be, m_wdata);
    end
    tick(); tick();
    issue64(1'b0, 3'b011, 32'h0000_0104, 64'h0);
    n_tests++;
    if ({r_valid, r_err, m_req} !== 4'b1010) begin
      n_fail++;
      $display("FAIL x64_ld_mis got %b exp 1010", {r_valid, r_err, m_req});
    end
    tick();
    m_gnt = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    q_valid = 1'b0; q_write = 1'b0; q_size = 3'b000;
    q_addr = 32'h0; q_wdata = 64'h0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 64'h0;
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_store_byte();
    test_store_held();
    test_loads();
    test_illegal();
    test_req_timeout();
    test_wait_timeout(1'b1);
    test_wait_timeout(1'b0);
    test_reset_mid();
    test_xlen64();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
